// File: rtl/round_sequencer_pkg.sv
// Shared types and constants for the memory-game round controller.
package game_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RST_PULSE = 3'd1,
    GEN       = 3'd2,
    SHOW      = 3'd3,
    INPUT     = 3'd4,
    JUDGE     = 3'd5,
    GAP       = 3'd6,
    DONE      = 3'd7
  } state_t;

  localparam int SCORE_PER_WIN      = 10;
  localparam int DEFAULT_NUM_ROUNDS = 10;
  localparam int CNT_W              = 24;

  // 10*wins as (w<<3)+(w<<1); wins <= 12 keeps the result below 128.
  function automatic logic [6:0] score_of(input logic [3:0] wins);
    logic [6:0] w;
    w = {3'b000, wins};
    return (w << 3) + (w << 1);
  endfunction

endpackage

// File: rtl/round_sequencer_if.sv
// Handshake and status bundle between the round controller and its round modules.
interface round_sequencer_if;
  logic       start;
  logic       level_valid;
  logic       pattern_gen_end;
  logic       print_pattern_end;
  logic       input_trim_end;
  logic       round_win;
  logic       round_rst_n;
  logic       pattern_gen_en;
  logic [4:0] round_count;
  logic [3:0] answer_count;
  logic [6:0] score;
  logic       game_end;
  logic [2:0] state_dbg;

  modport master (
    input  start, level_valid, pattern_gen_end, print_pattern_end,
           input_trim_end, round_win,
    output round_rst_n, pattern_gen_en, round_count, answer_count,
           score, game_end, state_dbg
  );

  modport slave (
    output start, level_valid, pattern_gen_end, print_pattern_end,
           input_trim_end, round_win,
    input  round_rst_n, pattern_gen_en, round_count, answer_count,
           score, game_end, state_dbg
  );
endinterface

// File: rtl/round_sequencer_start_sync.sv
// Two-flop synchronizer for the raw start key plus a rising-edge pulse.
module start_sync (
  input  logic clk_1,
  input  logic rst,
  input  logic start,
  output logic start_pulse
);

  logic sync1_r;
  logic sync2_r;
  logic prev_r;

  // Synchronize the asynchronous key and keep one delayed copy for edge detection.
  always_ff @(posedge clk_1 or negedge rst) begin
    if (!rst) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      prev_r  <= 1'b0;
    end else begin
      sync1_r <= start;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
    end
  end

  assign start_pulse = sync2_r & ~prev_r;

endmodule

// File: rtl/round_sequencer.sv
// Round controller: sequences reset pulse, generation, playback, input,
// judging and the inter-round gap, and keeps the game counters.
module round_sequencer
  import game_pkg::*;
#(
  parameter int NUM_ROUNDS       = DEFAULT_NUM_ROUNDS,
  parameter int RST_PULSE_CYCLES = 3,
  parameter int GAP_CYCLES       = 4,
  parameter int TIMEOUT_CYCLES   = 0
) (
  input logic               clk_1,
  input logic               rst,
  round_sequencer_if.master bus
);

  state_t             state_r;
  state_t             next_state_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [CNT_W-1:0]   cnt_load_s;
  logic               start_pulse_s;
  logic               timeout_s;
  logic               win_r;
  logic [4:0]         round_count_r;
  logic [3:0]         answer_count_r;
  logic [6:0]         score_r;
  logic [4:0]         round_next_s;
  logic [3:0]         answer_next_s;
  logic               last_round_s;
  logic               round_rst_n_s;
  logic               pattern_gen_en_s;
  logic               game_end_s;
  logic               round_rst_n_r;
  logic               pattern_gen_en_r;
  logic               game_end_r;

  start_sync u_start_sync (
    .clk_1       (clk_1),
    .rst         (rst),
    .start       (bus.start),
    .start_pulse (start_pulse_s)
  );

  assign timeout_s     = (TIMEOUT_CYCLES != 0) && (cnt_r == 24'd0);
  assign round_next_s  = round_count_r + 5'd1;
  assign answer_next_s = answer_count_r + {3'b000, win_r};
  assign last_round_s  = (round_next_s == 5'(NUM_ROUNDS));

  // State register.
  always_ff @(posedge clk_1 or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode; end inputs are only looked at in their own state.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE:      if (start_pulse_s && bus.level_valid) next_state_s = RST_PULSE;
                 else next_state_s = IDLE;
      RST_PULSE: if (cnt_r == 24'd0) next_state_s = GEN;
                 else next_state_s = RST_PULSE;
      GEN:       if (bus.pattern_gen_end) next_state_s = SHOW;
                 else next_state_s = GEN;
      SHOW:      if (bus.print_pattern_end) next_state_s = INPUT;
                 else next_state_s = SHOW;
      INPUT:     if (bus.input_trim_end || timeout_s) next_state_s = JUDGE;
                 else next_state_s = INPUT;
      JUDGE:     if (last_round_s) next_state_s = DONE;
                 else if (GAP_CYCLES == 0) next_state_s = RST_PULSE;
                 else next_state_s = GAP;
      GAP:       if (cnt_r == 24'd0) next_state_s = RST_PULSE;
                 else next_state_s = GAP;
      DONE:      next_state_s = DONE;
      default:   next_state_s = IDLE;
    endcase
  end

  // Reload value of the shared down-counter for the state being entered.
  always_comb begin
    cnt_load_s = 24'd0;
    case (next_state_s)
      RST_PULSE: cnt_load_s = CNT_W'(RST_PULSE_CYCLES - 1);
      GAP:       if (GAP_CYCLES == 0) cnt_load_s = 24'd0;
                 else cnt_load_s = CNT_W'(GAP_CYCLES - 1);
      INPUT:     if (TIMEOUT_CYCLES == 0) cnt_load_s = 24'd0;
                 else cnt_load_s = CNT_W'(TIMEOUT_CYCLES - 1);
      default:   cnt_load_s = 24'd0;
    endcase
  end

  // Shared down-counter: reload on state entry, count down to zero otherwise.
  always_ff @(posedge clk_1 or negedge rst) begin
    if (!rst) begin
      cnt_r <= 24'd0;
    end else if (next_state_s != state_r) begin
      cnt_r <= cnt_load_s;
    end else if (cnt_r != 24'd0) begin
      cnt_r <= cnt_r - 24'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Latch the round verdict on INPUT exit; a pure timeout scores nothing.
  always_ff @(posedge clk_1 or negedge rst) begin
    if (!rst) begin
      win_r <= 1'b0;
    end else if ((state_r == INPUT) && (next_state_s == JUDGE)) begin
      win_r <= bus.input_trim_end & bus.round_win;
    end else begin
      win_r <= win_r;
    end
  end

  // Game counters update at the end of JUDGE; score freezes on the last round.
  always_ff @(posedge clk_1 or negedge rst) begin
    if (!rst) begin
      round_count_r  <= 5'd0;
      answer_count_r <= 4'd0;
      score_r        <= 7'd0;
    end else if (state_r == JUDGE) begin
      round_count_r  <= round_next_s;
      answer_count_r <= answer_next_s;
      if (last_round_s) begin
        score_r <= score_of(answer_next_s);
      end else begin
        score_r <= score_r;
      end
    end else begin
      round_count_r  <= round_count_r;
      answer_count_r <= answer_count_r;
      score_r        <= score_r;
    end
  end

  // Output decode from the upcoming state so the registered outputs track state_r.
  always_comb begin
    round_rst_n_s    = 1'b0;
    pattern_gen_en_s = 1'b0;
    game_end_s       = 1'b0;
    case (next_state_s)
      IDLE, RST_PULSE: begin
        round_rst_n_s    = 1'b0;
        pattern_gen_en_s = 1'b0;
      end
      GEN, SHOW, INPUT, JUDGE: begin
        round_rst_n_s    = 1'b1;
        pattern_gen_en_s = 1'b1;
      end
      GAP: begin
        round_rst_n_s    = 1'b1;
        pattern_gen_en_s = 1'b0;
      end
      DONE: begin
        round_rst_n_s    = 1'b1;
        pattern_gen_en_s = 1'b0;
        game_end_s       = 1'b1;
      end
      default: begin
        round_rst_n_s    = 1'b0;
        pattern_gen_en_s = 1'b0;
      end
    endcase
  end

  // Output registers.
  always_ff @(posedge clk_1 or negedge rst) begin
    if (!rst) begin
      round_rst_n_r    <= 1'b0;
      pattern_gen_en_r <= 1'b0;
      game_end_r       <= 1'b0;
    end else begin
      round_rst_n_r    <= round_rst_n_s;
      pattern_gen_en_r <= pattern_gen_en_s;
      game_end_r       <= game_end_s;
    end
  end

  assign bus.round_rst_n    = round_rst_n_r;
  assign bus.pattern_gen_en = pattern_gen_en_r;
  assign bus.round_count    = round_count_r;
  assign bus.answer_count   = answer_count_r;
  assign bus.score          = score_r;
  assign bus.game_end       = game_end_r;
  assign bus.state_dbg      = state_r;

endmodule

// File: doc/round_sequencer.md
# round_sequencer

Central round controller for the memory game. It replaces the ad-hoc lrst/delay glue with one FSM clocked on clk_1, and sequences each round:
- round reset pulse
- pattern generation
- LED playback
- player input
- judge
- inter-round gap

It owns round_count, answer_count, score and game_end, and drives the round-local reset and enable of pattern_generator, print_pattern and input_trim.

## Interface
Parameters:
- NUM_ROUNDS, 10: rounds per game; legal range 1..12, so score stays below 128.
- RST_PULSE_CYCLES, 3: length of the round_rst_n low pulse; legal range 1..15.
- GAP_CYCLES, 4: idle cycles between JUDGE and the next round; 0 is legal.
- TIMEOUT_CYCLES, 0: input-phase timeout in clk_1 cycles; 0 disables it; maximum 2^24-1.

Ports:
- clk_1  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  raw keypad_0, asynchronous level.
- level_valid  in  1  level_select end_signal, held high.
- pattern_gen_end  in  1  pattern_generator done, held until round reset.
- print_pattern_end  in  1  playback done, held.
- input_trim_end  in  1  player input complete, held.
- round_win  in  1  combinational pattern==input compare, valid while input_trim_end=1.
- round_rst_n  out  1  active-low reset to the three round modules.
- pattern_gen_en  out  1  enable to pattern_generator.
- round_count  out  5  rounds judged so far.
- answer_count  out  4  rounds won.
- score  out  7  10*answer_count, latched on game end.
- game_end  out  1  game finished.
- state_dbg  out  3  current state encoding.

## Operation
- start passes through a 2-flop synchronizer and rising-edge detector, producing start_pulse.
- IDLE: round_rst_n=0, pattern_gen_en=0. start_pulse & level_valid -> RST_PULSE. start_pulse without level_valid is ignored.
- RST_PULSE: round_rst_n=0 for exactly RST_PULSE_CYCLES cycles -> GEN.
- GEN: round_rst_n=1, pattern_gen_en=1; pattern_gen_end -> SHOW.
- SHOW: pattern_gen_en stays 1; print_pattern_end -> INPUT.
- INPUT: pattern_gen_en stays 1. Exit to JUDGE on either:
  - input_trim_end, or
  - timeout, i.e. TIMEOUT_CYCLES!=0 and the cycle counter reaches TIMEOUT_CYCLES-1.
  - If both occur in the same cycle, completion wins.
- JUDGE (1 cycle):
  - round_count += 1.
  - answer_count += round_win, but only when the exit was not a timeout; a timeout scores 0.
  - If the new round_count == NUM_ROUNDS -> DONE, else -> GAP.
- GAP: round_rst_n=1, pattern_gen_en=0 for GAP_CYCLES cycles -> RST_PULSE. With GAP_CYCLES=0, go directly to RST_PULSE.
- DONE: game_end=1, pattern_gen_en=0, round_rst_n=1 so LEDs and inputs freeze. Terminal until rst; start is ignored.
- Score: score <= answer_count*10, computed as (a<<3)+(a<<1) in 7 bits. Registered on the JUDGE->DONE transition using the updated answer_count, then constant.
- Stale held-high end signals from the previous round cannot leak: each round passes RST_PULSE before GEN, and the end inputs are sampled only in their own state.

## Timing
- Reset values: state IDLE, round_rst_n=0, pattern_gen_en=0, round_count=0, answer_count=0, score=0, game_end=0, all internal counters 0.
- Asserting rst in any state returns to IDLE on the same edge. Deassertion needs no synchronizer inside this block; it is sync-released at top level.
- start to RST_PULSE entry: 3 cycles after start rises (2 sync + 1 edge register).
- Each handshake advances the cycle after the end input is sampled high. Example: pattern_gen_end high in the first GEN cycle gives SHOW in the next cycle.
- JUDGE is exactly 1 cycle. round_count and answer_count update at its end. game_end rises together with DONE entry.
- Round overhead outside module handshakes: RST_PULSE_CYCLES + 1 (JUDGE) + GAP_CYCLES.
- Counters never wrap: round_count ≤ NUM_ROUNDS ≤ 12 and answer_count ≤ round_count.

## Structure
- Package game_pkg holds:
  - typedef enum logic [2:0] state_t {IDLE, RST_PULSE, GEN, SHOW, INPUT, JUDGE, GAP, DONE}
  - SCORE_PER_WIN=10
  - default NUM_ROUNDS
- One sub-module: start_sync, the 2-flop synchronizer plus rising-edge pulse, reset by rst.
- A single 24-bit down-counter is shared by RST_PULSE, GAP and the INPUT timeout; it reloads on each state entry.

## Test plan
- Defaults; start without level_valid -> stays IDLE. Set level_valid, pulse start -> round_rst_n low exactly 3 cycles, then pattern_gen_en=1.
- 10 rounds, round_win=1 on rounds 1-7 and 0 on rounds 8-10 -> round_count=10, answer_count=7, score=70, game_end=1. Further start pulses have no effect.
- Hold all end signals high permanently -> every round still shows a 3-cycle reset pulse. Each state lasts exactly 1 cycle and the gap 4 cycles; no round skipped.
- TIMEOUT_CYCLES=20, input_trim_end never rises -> JUDGE at INPUT cycle 20, answer_count unchanged even with round_win=1. Same case with input_trim_end and timeout coinciding -> answer_count increments.
- Assert rst during INPUT of round 5 -> same-edge IDLE, all outputs at reset values. Restart -> round_count counts from 0.
- NUM_ROUNDS=12, all rounds won -> score=120, no overflow.
